// File: rtl/relogio_pkg.sv
// ---------------------------------------------------------------------------
// relogio_pkg
//
// Shared definitions for the real-time clock counter:
//   - BCD digit limits used by the digit counters and the hour wrap
//   - hhmm_t : packed HH:MM record used for the alarm setting
//   - bcd_onehot : 4-bit BCD digit -> 10-bit one-hot display code
//   - hm_valid / time_valid : range checks applied to load requests
// ---------------------------------------------------------------------------
package relogio_pkg;

    // Width of every one-hot display digit (digit d drives bit d)
    localparam int ONEHOT_W = 10;

    // BCD limits: units of any field run 0..9, tens of seconds/minutes 0..5
    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    // Hours run 00..23; the hour pair wraps when it reads "23"
    localparam int         HOUR_MAX          = 23;
    localparam logic [1:0] HOUR_TENS_MAX     = 2'd2;
    localparam logic [3:0] HOUR_UNITS_AT_TOP = 4'd3;

    // Alarm setting: hours and minutes only
    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } hhmm_t;

    // Digits above 9 can never be stored, but the decoder still returns a
    // legal code (digit 0) so a display is never dark or multi-lit.
    function automatic logic [ONEHOT_W-1:0] bcd_onehot(input logic [3:0] d);
        logic [ONEHOT_W-1:0] v;
        v = ONEHOT_W'(1);
        if (d <= UNITS_MAX) begin
            v = ONEHOT_W'(1) << d;
        end
        return v;
    endfunction

    // HH:MM range check; the units test is needed separately because
    // e.g. "0" "12" would otherwise pass as hour 12.
    function automatic logic hm_valid(input logic [1:0] h1,
                                      input logic [3:0] h0,
                                      input logic [3:0] m1,
                                      input logic [3:0] m0);
        logic ok;
        ok = (h0 <= UNITS_MAX)
           && ((int'(h1) * 10 + int'(h0)) <= HOUR_MAX)
           && (m1 <= TENS_MAX)
           && (m0 <= UNITS_MAX);
        return ok;
    endfunction

    // Full HH:MM:SS range check used by the time load
    function automatic logic time_valid(input logic [1:0] h1,
                                        input logic [3:0] h0,
                                        input logic [3:0] m1,
                                        input logic [3:0] m0,
                                        input logic [3:0] s1,
                                        input logic [3:0] s0);
        return hm_valid(h1, h0, m1, m0)
            && (s1 <= TENS_MAX)
            && (s0 <= UNITS_MAX);
    endfunction

endpackage

// File: rtl/contador_mod.sv
// ---------------------------------------------------------------------------
// contador_mod
//
// One BCD digit counting 0..MAX_VAL with wrap, synchronous load and a
// carry that lets the next digit advance on the same clock edge.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset (digit -> 0)
//   i_en       in   advance by one on this edge
//   i_load     in   load i_load_val (has priority over i_en)
//   i_load_val in   value to load
//   o_digit    out  current digit
//   o_carry    out  high when this digit wraps on the current edge
// ---------------------------------------------------------------------------
module contador_mod
    import relogio_pkg::*;
#(
    parameter logic [3:0] MAX_VAL = UNITS_MAX
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_en,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    output logic [3:0] o_digit,
    output logic       o_carry
);

    logic [3:0] r_digit;

    // Digit register: load wins, otherwise count with wrap at MAX_VAL
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digit <= 4'd0;
        end else if (i_load) begin
            r_digit <= i_load_val;
        end else if (i_en) begin
            r_digit <= (r_digit == MAX_VAL) ? 4'd0 : r_digit + 4'd1;
        end
    end

    assign o_digit = r_digit;

    // A carry only exists when the digit really wraps this edge
    assign o_carry = i_en & ~i_load & (r_digit == MAX_VAL);

endmodule

// File: rtl/relogio_johnson_param.sv
// ---------------------------------------------------------------------------
// relogio_johnson_param
//
// Real-time clock keeping HH:MM:SS as BCD digits, advancing once per
// TICK_DIV enabled clock cycles. Time is always held in 24-hour form;
// mode12 only changes the displayed hour and the pm flag.
//
// Ports:
//   clk, reset_n          clock / asynchronous active-low reset
//   run                   1 = prescaler and time advance, 0 = frozen
//   LD                    load HH:MM:SS from the *_in digits (validated)
//   ALD                   load alarm HH:MM from the *_in digits (validated)
//   alarm_en              gates alarm_hit
//   mode12                1 = 12-hour display with pm flag
//   H_in1..S_in0          BCD load digits
//   *_johnson             one-hot displayed digits (10 bits each)
//   pm                    afternoon flag in 12-hour mode
//   alarm_hit             pulse: time just became alarm HH:MM:00
//   day_pulse             pulse: time just rolled 23:59:59 -> 00:00:00
//   ld_err                pulse: LD and/or ALD carried invalid digits
// ---------------------------------------------------------------------------
module relogio_johnson_param
    import relogio_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int DIGIT_W  = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               LD,
    input  logic               ALD,
    input  logic               alarm_en,
    input  logic               mode12,
    input  logic [1:0]         H_in1,
    input  logic [3:0]         H_in0,
    input  logic [3:0]         M_in1,
    input  logic [3:0]         M_in0,
    input  logic [3:0]         S_in1,
    input  logic [3:0]         S_in0,
    output logic [DIGIT_W-1:0] H_out1_johnson,
    output logic [DIGIT_W-1:0] H_out0_johnson,
    output logic [DIGIT_W-1:0] M_out1_johnson,
    output logic [DIGIT_W-1:0] M_out0_johnson,
    output logic [DIGIT_W-1:0] S_out1_johnson,
    output logic [DIGIT_W-1:0] S_out0_johnson,
    output logic               pm,
    output logic               alarm_hit,
    output logic               day_pulse,
    output logic               ld_err
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_TOP = PW'(TICK_DIV - 1);

    logic [PW-1:0] r_presc;
    logic [1:0]    r_h1;
    logic [3:0]    r_h0;
    hhmm_t         r_alarm;
    logic          r_day_pulse;
    logic          r_ld_err;
    logic          r_advanced;

    logic          w_ld_ok;
    logic          w_ld_bad;
    logic          w_ald_ok;
    logic          w_ald_bad;
    logic          w_tick;
    logic          w_day_roll;

    logic [3:0]    w_s0, w_s1, w_m0, w_m1;
    logic          w_c_s0, w_c_s1, w_c_m0, w_c_m1;

    logic [4:0]    w_hour_bin;
    logic [4:0]    w_disp_hour;
    logic [3:0]    w_disp_h1;
    logic [3:0]    w_disp_h0;
    logic          w_alarm_match;

    // Load requests are split into accepted and rejected halves up front
    assign w_ld_ok   = LD  &  time_valid(H_in1, H_in0, M_in1, M_in0, S_in1, S_in0);
    assign w_ld_bad  = LD  & ~time_valid(H_in1, H_in0, M_in1, M_in0, S_in1, S_in0);
    assign w_ald_ok  = ALD &  hm_valid(H_in1, H_in0, M_in1, M_in0);
    assign w_ald_bad = ALD & ~hm_valid(H_in1, H_in0, M_in1, M_in0);

    // Any LD (valid or not) blocks the tick, so a coincident second is lost
    assign w_tick = run & ~LD & (r_presc == PRESC_TOP);

    // Prescaler: cleared by a valid load, counts only while running with
    // no load pending, wraps after the tick cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_presc <= '0;
        end else if (w_ld_ok) begin
            r_presc <= '0;
        end else if (run && !LD) begin
            r_presc <= (r_presc == PRESC_TOP) ? '0 : r_presc + PW'(1);
        end
    end

    // Seconds and minutes digits; each carry feeds the next enable so the
    // whole chain resolves on a single edge.
    contador_mod #(.MAX_VAL(UNITS_MAX)) u_s0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_tick),
        .i_load     (w_ld_ok),
        .i_load_val (S_in0),
        .o_digit    (w_s0),
        .o_carry    (w_c_s0)
    );

    contador_mod #(.MAX_VAL(TENS_MAX)) u_s1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_c_s0),
        .i_load     (w_ld_ok),
        .i_load_val (S_in1),
        .o_digit    (w_s1),
        .o_carry    (w_c_s1)
    );

    contador_mod #(.MAX_VAL(UNITS_MAX)) u_m0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_c_s1),
        .i_load     (w_ld_ok),
        .i_load_val (M_in0),
        .o_digit    (w_m0),
        .o_carry    (w_c_m0)
    );

    contador_mod #(.MAX_VAL(TENS_MAX)) u_m1 (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_en       (w_c_m0),
        .i_load     (w_ld_ok),
        .i_load_val (M_in1),
        .o_digit    (w_m1),
        .o_carry    (w_c_m1)
    );

    // The hour pair wraps at "23" rather than at a per-digit limit, so it
    // is kept together here instead of as two independent digit counters.
    assign w_day_roll = w_c_m1 & (r_h1 == HOUR_TENS_MAX) & (r_h0 == HOUR_UNITS_AT_TOP);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_h1 <= 2'd0;
            r_h0 <= 4'd0;
        end else if (w_ld_ok) begin
            r_h1 <= H_in1;
            r_h0 <= H_in0;
        end else if (w_c_m1) begin
            if (w_day_roll) begin
                r_h1 <= 2'd0;
                r_h0 <= 4'd0;
            end else if (r_h0 == UNITS_MAX) begin
                r_h1 <= r_h1 + 2'd1;
                r_h0 <= 4'd0;
            end else begin
                r_h0 <= r_h0 + 4'd1;
            end
        end
    end

    // Alarm setting register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alarm <= '0;
        end else if (w_ald_ok) begin
            r_alarm.h1 <= H_in1;
            r_alarm.h0 <= H_in0;
            r_alarm.m1 <= M_in1;
            r_alarm.m0 <= M_in0;
        end
    end

    // Event flags for the cycle after the edge. r_advanced marks that the
    // time just changed by a tick or a load, which is when an alarm match
    // is allowed to fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_day_pulse <= 1'b0;
            r_ld_err    <= 1'b0;
            r_advanced  <= 1'b0;
        end else begin
            r_day_pulse <= w_day_roll;
            r_ld_err    <= w_ld_bad | w_ald_bad;
            r_advanced  <= w_tick | w_ld_ok;
        end
    end

    // Alarm fires only on the exact HH:MM:00 the time has just reached
    assign w_alarm_match = (r_h1 == r_alarm.h1) && (r_h0 == r_alarm.h0)
                        && (w_m1 == r_alarm.m1) && (w_m0 == r_alarm.m0)
                        && (w_s1 == 4'd0) && (w_s0 == 4'd0);

    assign alarm_hit = r_advanced & alarm_en & w_alarm_match;
    assign day_pulse = r_day_pulse;
    assign ld_err    = r_ld_err;

    // Display hour mapping: 0 shows as 12, 13..23 show as 1..11 in 12-hour
    // mode; the result is split back into BCD tens/units for the decoder.
    always_comb begin
        w_hour_bin  = 5'(r_h1) * 5'd10 + 5'(r_h0);
        w_disp_hour = w_hour_bin;
        w_disp_h1   = 4'd0;
        w_disp_h0   = 4'd0;
        if (mode12) begin
            if (w_hour_bin == 5'd0) begin
                w_disp_hour = 5'd12;
            end else if (w_hour_bin > 5'd12) begin
                w_disp_hour = w_hour_bin - 5'd12;
            end
        end
        if (w_disp_hour >= 5'd20) begin
            w_disp_h1 = 4'd2;
            w_disp_h0 = 4'(w_disp_hour - 5'd20);
        end else if (w_disp_hour >= 5'd10) begin
            w_disp_h1 = 4'd1;
            w_disp_h0 = 4'(w_disp_hour - 5'd10);
        end else begin
            w_disp_h1 = 4'd0;
            w_disp_h0 = 4'(w_disp_hour);
        end
    end

    assign pm = mode12 & (w_hour_bin >= 5'd12);

    assign H_out1_johnson = DIGIT_W'(bcd_onehot(w_disp_h1));
    assign H_out0_johnson = DIGIT_W'(bcd_onehot(w_disp_h0));
    assign M_out1_johnson = DIGIT_W'(bcd_onehot(w_m1));
    assign M_out0_johnson = DIGIT_W'(bcd_onehot(w_m0));
    assign S_out1_johnson = DIGIT_W'(bcd_onehot(w_s1));
    assign S_out0_johnson = DIGIT_W'(bcd_onehot(w_s0));

endmodule

// File: tb/tb_relogio_johnson_param.sv
// ---------------------------------------------------------------------------
// tb_relogio_johnson_param
//
// Two instances share one stimulus: one with a 4-cycle second and one that
// ticks every enabled cycle. A reference model keeps time as a plain count
// of seconds since midnight and the alarm as minutes since midnight.
// ---------------------------------------------------------------------------
module tb_relogio_johnson_param;

    logic clk = 1'b0;
    logic reset_n, run, LD, ALD, alarm_en, mode12;
    logic [1:0] H_in1;
    logic [3:0] H_in0, M_in1, M_in0, S_in1, S_in0;

    logic [9:0] a_h1, a_h0, a_m1, a_m0, a_s1, a_s0;
    logic       a_pm, a_hit, a_day, a_err;
    logic [9:0] b_h1, b_h0, b_m1, b_m0, b_s1, b_s0;
    logic       b_pm, b_hit, b_day, b_err;

    int DIVS [2] = '{4, 1};
    int mSecs [2];
    int mPresc [2];
    int mAlarm [2];
    bit mDay [2];
    bit mErr [2];
    bit mAdv [2];

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    relogio_johnson_param #(.TICK_DIV(4), .DIGIT_W(10)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .run(run), .LD(LD), .ALD(ALD),
        .alarm_en(alarm_en), .mode12(mode12),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .S_in1(S_in1), .S_in0(S_in0),
        .H_out1_johnson(a_h1), .H_out0_johnson(a_h0),
        .M_out1_johnson(a_m1), .M_out0_johnson(a_m0),
        .S_out1_johnson(a_s1), .S_out0_johnson(a_s0),
        .pm(a_pm), .alarm_hit(a_hit), .day_pulse(a_day), .ld_err(a_err)
    );

    relogio_johnson_param #(.TICK_DIV(1), .DIGIT_W(10)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .run(run), .LD(LD), .ALD(ALD),
        .alarm_en(alarm_en), .mode12(mode12),
        .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .S_in1(S_in1), .S_in0(S_in0),
        .H_out1_johnson(b_h1), .H_out0_johnson(b_h0),
        .M_out1_johnson(b_m1), .M_out0_johnson(b_m0),
        .S_out1_johnson(b_s1), .S_out0_johnson(b_s0),
        .pm(b_pm), .alarm_hit(b_hit), .day_pulse(b_day), .ld_err(b_err)
    );

    // Plain range check on decimal digits
    function automatic bit digitsOk(int h1, int h0, int m1, int m0, int s1, int s0, bit useSecs);
        bit ok;
        ok = (h0 <= 9) && (h1 * 10 + h0 <= 23) && (m1 <= 5) && (m0 <= 9);
        if (useSecs) ok = ok && (s1 <= 5) && (s0 <= 9);
        return ok;
    endfunction

    function automatic logic [9:0] oh(int d);
        logic [9:0] v;
        v = 10'd1;
        return v << d;
    endfunction

    function automatic int dispHour(int h, bit m12);
        if (!m12) return h;
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    // Model state after an asynchronous reset
    function automatic void modelReset();
        for (int k = 0; k < 2; k++) begin
            mSecs[k] = 0; mPresc[k] = 0; mAlarm[k] = 0;
            mDay[k] = 0; mErr[k] = 0; mAdv[k] = 0;
        end
    endfunction

    // One rising edge of the model, using the inputs present at that edge
    function automatic void modelEdge();
        bit ldOk, aldOk, tick;
        int hi1, hi0, mi1, mi0, si1, si0;
        hi1 = int'(H_in1); hi0 = int'(H_in0); mi1 = int'(M_in1);
        mi0 = int'(M_in0); si1 = int'(S_in1); si0 = int'(S_in0);
        ldOk  = LD  && digitsOk(hi1, hi0, mi1, mi0, si1, si0, 1'b1);
        aldOk = ALD && digitsOk(hi1, hi0, mi1, mi0, si1, si0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tick = run && !LD && (mPresc[k] == DIVS[k] - 1);
            mDay[k] = tick && (mSecs[k] == 86399);
            mErr[k] = (LD && !ldOk) || (ALD && !aldOk);
            mAdv[k] = tick || ldOk;
            if (ldOk) begin
                mSecs[k]  = (hi1 * 10 + hi0) * 3600 + (mi1 * 10 + mi0) * 60 + si1 * 10 + si0;
                mPresc[k] = 0;
            end else begin
                if (run && !LD) mPresc[k] = (mPresc[k] + 1) % DIVS[k];
                if (tick) mSecs[k] = (mSecs[k] + 1) % 86400;
            end
            if (aldOk) mAlarm[k] = (hi1 * 10 + hi0) * 60 + mi1 * 10 + mi0;
        end
    endfunction

    task automatic chk(string tag, logic [9:0] obs, logic [9:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Compare every output of both instances against the model
    task automatic checkOutput(string tag);
        logic [9:0] o [6];
        logic [3:0] f;
        int h, m, s, dh;
        bit eHit;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                o[0] = a_h1; o[1] = a_h0; o[2] = a_m1; o[3] = a_m0; o[4] = a_s1; o[5] = a_s0;
                f = {a_pm, a_hit, a_day, a_err};
            end else begin
                o[0] = b_h1; o[1] = b_h0; o[2] = b_m1; o[3] = b_m0; o[4] = b_s1; o[5] = b_s0;
                f = {b_pm, b_hit, b_day, b_err};
            end
            h = mSecs[k] / 3600;
            m = (mSecs[k] / 60) % 60;
            s = mSecs[k] % 60;
            dh = dispHour(h, mode12);
            eHit = mAdv[k] && alarm_en && (s == 0) && (mSecs[k] / 60 == mAlarm[k]);
            chk($sformatf("%s_div%0d_H1", tag, DIVS[k]), o[0], oh(dh / 10));
            chk($sformatf("%s_div%0d_H0", tag, DIVS[k]), o[1], oh(dh % 10));
            chk($sformatf("%s_div%0d_M1", tag, DIVS[k]), o[2], oh(m / 10));
            chk($sformatf("%s_div%0d_M0", tag, DIVS[k]), o[3], oh(m % 10));
            chk($sformatf("%s_div%0d_S1", tag, DIVS[k]), o[4], oh(s / 10));
            chk($sformatf("%s_div%0d_S0", tag, DIVS[k]), o[5], oh(s % 10));
            chk($sformatf("%s_div%0d_pm", tag, DIVS[k]), {9'd0, f[3]}, {9'd0, mode12 && (h >= 12)});
            chk($sformatf("%s_div%0d_hit", tag, DIVS[k]), {9'd0, f[2]}, {9'd0, eHit});
            chk($sformatf("%s_div%0d_day", tag, DIVS[k]), {9'd0, f[1]}, {9'd0, mDay[k]});
            chk($sformatf("%s_div%0d_err", tag, DIVS[k]), {9'd0, f[0]}, {9'd0, mErr[k]});
        end
    endtask

    // Advance n clock edges, updating the model and checking after each
    task automatic applyStimulus(int n, string tag);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            modelEdge();
            checkOutput($sformatf("%s%0d", tag, i));
        end
    endtask

    task automatic setDigits(int h1, int h0, int m1, int m0, int s1, int s0);
        H_in1 = 2'(h1); H_in0 = 4'(h0);
        M_in1 = 4'(m1); M_in0 = 4'(m0);
        S_in1 = 4'(s1); S_in0 = 4'(s0);
    endtask

    task automatic loadTime(int hh, int mm, int ss, string tag);
        setDigits(hh / 10, hh % 10, mm / 10, mm % 10, ss / 10, ss % 10);
        LD = 1'b1;
        applyStimulus(1, tag);
        LD = 1'b0;
    endtask

    // Directed steps followed by a randomized stretch
    initial begin
        reset_n = 1'b0; run = 1'b0; LD = 1'b0; ALD = 1'b0;
        alarm_en = 1'b0; mode12 = 1'b0;
        setDigits(0, 0, 0, 0, 0, 0);
        modelReset();

        @(posedge clk);
        #1;
        checkOutput("rst24");
        chk("rst_S0_onehot", a_s0, 10'b0000000001);
        mode12 = 1'b1;
        #1;
        checkOutput("rst12");
        mode12 = 1'b0;
        reset_n = 1'b1;
        run = 1'b1;

        // First second on the 4-cycle instance
        applyStimulus(4, "first");
        chk("first_sec_S0_div4", a_s0, 10'b0000000010);

        // Midnight rollover
        loadTime(23, 59, 58, "ld235958_");
        applyStimulus(1, "roll_a");
        chk("before_roll_day_div1", {9'd0, b_day}, 10'd0);
        applyStimulus(1, "roll_b");
        chk("roll_day_div1", {9'd0, b_day}, 10'd1);
        chk("roll_H1_div1", b_h1, 10'b0000000001);
        chk("roll_H0_div1", b_h0, 10'b0000000001);
        applyStimulus(1, "roll_c");
        chk("after_roll_day_div1", {9'd0, b_day}, 10'd0);

        // Invalid loads
        setDigits(2, 4, 0, 0, 0, 0);
        LD = 1'b1;
        applyStimulus(1, "bad24_");
        LD = 1'b0;
        chk("bad24_err_div4", {9'd0, a_err}, 10'd1);
        applyStimulus(1, "bad24_after");
        setDigits(1, 2, 6, 0, 0, 0);
        LD = 1'b1;
        applyStimulus(1, "badM1_");
        LD = 1'b0;
        chk("badM1_err_div1", {9'd0, b_err}, 10'd1);

        // Full carry chain on one tick
        loadTime(9, 59, 59, "ld095959_");
        applyStimulus(4, "carry");
        chk("carry_H1_div4", a_h1, 10'b0000000010);
        chk("carry_M1_div4", a_m1, 10'b0000000001);

        // 12-hour display
        mode12 = 1'b1;
        loadTime(0, 30, 0, "m12_0030_");
        chk("m12_0030_H1_div4", a_h1, 10'b0000000010);
        chk("m12_0030_H0_div4", a_h0, 10'b0000000100);
        loadTime(13, 5, 0, "m12_1305_");
        chk("m12_1305_pm_div4", {9'd0, a_pm}, 10'd1);
        loadTime(12, 0, 0, "m12_1200_");
        applyStimulus(2, "m12_run");
        mode12 = 1'b0;

        // Alarm enabled
        alarm_en = 1'b1;
        setDigits(0, 7, 0, 0, 0, 0);
        ALD = 1'b1;
        applyStimulus(1, "ald0700_");
        ALD = 1'b0;
        loadTime(6, 59, 59, "al_ld_");
        applyStimulus(1, "al_a");
        chk("alarm_hit_div1", {9'd0, b_hit}, 10'd1);
        applyStimulus(2, "al_b");
        applyStimulus(1, "al_c");
        chk("alarm_hit_div4", {9'd0, a_hit}, 10'd1);
        chk("alarm_once_div1", {9'd0, b_hit}, 10'd0);

        // Alarm disabled
        alarm_en = 1'b0;
        loadTime(6, 59, 59, "nal_ld_");
        applyStimulus(4, "nal");
        chk("no_alarm_div4", {9'd0, a_hit}, 10'd0);

        // Pause mid-count
        applyStimulus(2, "prerun");
        run = 1'b0;
        applyStimulus(10, "pause");
        run = 1'b1;
        applyStimulus(5, "resume");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            run      = ($urandom_range(0, 7) != 0);
            LD       = ($urandom_range(0, 15) == 0);
            ALD      = ($urandom_range(0, 15) == 0);
            alarm_en = ($urandom_range(0, 3) != 0);
            mode12   = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) begin
                setDigits(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end else begin
                setDigits(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 5)), int'($urandom_range(8, 9)),
                          5, int'($urandom_range(6, 9)));
            end
            applyStimulus(1, $sformatf("rnd%0d_", i));
        end

        // Asynchronous reset between clock edges
        LD = 1'b0; ALD = 1'b0; mode12 = 1'b0; run = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst");
        chk("async_S0_div4", a_s0, 10'b0000000001);
        #1;
        reset_n = 1'b1;
        applyStimulus(6, "post_rst");

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
